// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//   Synchronous single-clock FIFO built from a register bank. Head and tail
//   pointers carry one extra wrap bit, so full and empty can be told apart
//   without a separate counter. There is no bypass and no pass-through:
//   a new entry shows on deq_data the cycle after it is written, and a full
//   FIFO refuses an enqueue even while it is being dequeued.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   flush      discard all stored entries at the next edge
//   enq_valid  producer offers enq_data
//   enq_data   entry to store (WIDTH bits)
//   enq_ready  FIFO not full
//   deq_valid  FIFO not empty, head entry on deq_data
//   deq_data   oldest stored entry
//   deq_ready  consumer takes the head entry
//   count      stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [WIDTH-1:0]         enq_data,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_head;
    logic [AW:0]      r_tail;

    logic w_empty;
    logic w_full;
    logic w_enq_fire;
    logic w_deq_fire;

    assign w_empty = (r_head == r_tail);
    // Same slot but opposite lap: the tail has gone all the way round.
    assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

    // Ready/valid are functions of stored state only; flush acts at the edge.
    assign enq_ready  = !w_full;
    assign deq_valid  = !w_empty;
    assign deq_data   = r_mem[r_head[AW-1:0]];
    assign count      = r_tail - r_head;

    assign w_enq_fire = enq_valid && !w_full;
    assign w_deq_fire = deq_ready && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + PTR_ONE;
            if (w_deq_fire) r_head <= r_head + PTR_ONE;
        end
    end

    // Storage is not cleared by flush; the pointers alone make it invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_enq_fire && !flush) begin
            r_mem[r_tail[AW-1:0]] <= enq_data;
        end
    end

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   enq_valid;
    logic [WIDTH-1:0]       enq_data;
    logic                   enq_ready;
    logic                   deq_valid;
    logic [WIDTH-1:0]       deq_data;
    logic                   deq_ready;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake that will fire at the coming edge must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && !flush && deq_valid && deq_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL deq_unexpected: got 0x%0h expected no entry at %0t", deq_data, $time);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = sb.pop_front();
                if (deq_data !== exp) begin
                    errors++;
                    $display("FAIL deq_data: got 0x%0h expected 0x%0h at %0t", deq_data, exp, $time);
                end
            end
        end
    end

    // Drive one cycle of enqueue; 'accept' is the hand-computed outcome.
    task automatic enq(input logic [WIDTH-1:0] d, input bit accept);
        enq_valid = 1'b1;
        enq_data  = d;
        if (accept) sb.push_back(d);
        step();
        enq_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        deq_ready = 1'b1;
        repeat (n) step();
        deq_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
        #3;
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_count", count, 0);
        check("rst_deq_data", deq_data, 0);
        #9 rst = 1'b1;
        step();

        // Single entry, no bypass
        enq_valid = 1'b1; enq_data = 32'hA5A5A5A5; sb.push_back(32'hA5A5A5A5);
        #2 check("no_bypass_deq_valid", deq_valid, 0);
        step();
        enq_valid = 1'b0;
        check("single_deq_valid", deq_valid, 1);
        check("single_deq_data", deq_data, 32'hA5A5A5A5);
        check("single_count", count, 1);
        drain(1);
        check("single_empty", deq_valid, 0);

        // Fill to full, overflow attempt, drain in order
        for (int i = 1; i <= 8; i++) enq(i, 1'b1);
        check("full_count", count, 8);
        check("full_enq_ready", enq_ready, 0);
        enq(32'd9, 1'b0);
        check("overflow_count", count, 8);
        drain(8);
        check("drained_deq_valid", deq_valid, 0);
        check("drained_count", count, 0);

        // Full with simultaneous enq/deq: no pass-through, then both fire
        for (int i = 0; i < 8; i++) enq(32'h100 + i, 1'b1);
        enq_valid = 1'b1; deq_ready = 1'b1; enq_data = 32'h200;
        step();
        check("full_both_count", count, 7);
        enq_data = 32'h201; sb.push_back(32'h201);
        step();
        check("both_fire_count", count, 7);
        enq_valid = 1'b0; deq_ready = 1'b0;
        drain(7);
        check("after_full_drain_count", count, 0);

        // Streaming with occupancy 3 across many pointer wraps
        for (int i = 0; i < 3; i++) enq(32'h300 + i, 1'b1);
        deq_ready = 1'b1; enq_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            enq_data = 32'h400 + i;
            sb.push_back(32'h400 + i);
            step();
            if (i == 20 || i == 39) check("stream_count", count, 3);
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
        drain(3);
        check("stream_drained", count, 0);

        // Flush overrides a same-cycle enqueue and dequeue
        for (int i = 0; i < 5; i++) enq(32'h500 + i, 1'b1);
        check("preflush_count", count, 5);
        flush = 1'b1; enq_valid = 1'b1; enq_data = 32'hDEAD; deq_ready = 1'b1;
        step();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        sb.delete();
        check("flush_count", count, 0);
        check("flush_deq_valid", deq_valid, 0);
        check("flush_enq_ready", enq_ready, 1);
        enq(32'h77, 1'b1);
        drain(1);
        check("postflush_empty", deq_valid, 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) enq(32'h600 + i, 1'b1);
        check("prereset_count", count, 4);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_deq_valid", deq_valid, 0);
        check("async_rst_deq_data", deq_data, 0);
        sb.delete();
        #1 rst = 1'b1;
        step();
        enq(32'h1, 1'b1);
        check("postreset_count", count, 1);
        drain(1);
        check("postreset_empty", deq_valid, 0);

        step();
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
